// File: rtl/lfsr_checker.sv
// rtl/lfsr_checker.sv - PRBS receive checker: self-synchronising LFSR with lock detect and error counting
// Optional FIRST_ERR capture is built only when LFSR_CHECKER_FIRST_ERR_EN is defined.
module lfsr_checker #(
  parameter int              WIDTH       = 16,
  parameter logic [WIDTH-1:0] POLY       = 'hD008,
  parameter int              LOCK_COUNT  = 64,
  parameter int              UNLOCK_ERRS = 8,
  parameter int              CNT_WIDTH   = 32
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 CE,
  input  logic                 I,
  input  logic                 CLR,
  output logic                 LOCKED,
  output logic                 ERROR,
  output logic [CNT_WIDTH-1:0] ERR_COUNT,
  output logic [CNT_WIDTH-1:0] BIT_COUNT,
  output logic [CNT_WIDTH-1:0] FIRST_ERR
);

  localparam int                   FW         = $clog2(WIDTH + 1);
  localparam logic [FW-1:0]        FILL_LAST  = FW'(WIDTH - 1);
  localparam logic [FW-1:0]        FILL_ONE   = FW'(1);
  localparam logic [15:0]          RUN_TARGET = 16'(LOCK_COUNT);
  localparam logic [7:0]           ERR_TARGET = 8'(UNLOCK_ERRS);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE    = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX    = '1;

  typedef enum logic [1:0] {
    S_FILL,
    S_ACQUIRE,
    S_LOCK
  } state_t;

  state_t         state;
  logic [WIDTH-1:0] r;
  logic [FW-1:0]  fill_cnt;
  logic [15:0]    run_cnt;
  logic [7:0]     err_run;
  logic           p;
  logic           check_en;
  logic           mismatch;

  // p is the bit the local LFSR expects next; only bits seen in LOCK are judged
  assign p        = ^(r & POLY);
  assign check_en = CE && (state == S_LOCK);
  assign mismatch = check_en && (I != p);

  // Sync FSM: fill from the stream, qualify predictions, then flywheel on the prediction while locked
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= S_FILL;
      r        <= '0;
      fill_cnt <= '0;
      run_cnt  <= '0;
      err_run  <= '0;
      LOCKED   <= 1'b0;
    end else if (CE) begin
      case (state)
        S_FILL: begin
          r        <= {r[WIDTH-2:0], I};
          fill_cnt <= fill_cnt + FILL_ONE;
          if (fill_cnt == FILL_LAST) begin
            state   <= S_ACQUIRE;
            run_cnt <= '0;
          end
        end
        S_ACQUIRE: begin
          r <= {r[WIDTH-2:0], I};
          // an all-zero register predicts zero forever, so it must never earn credit
          if ((I == p) && (r != '0)) begin
            if (run_cnt + 16'd1 == RUN_TARGET) begin
              state   <= S_LOCK;
              LOCKED  <= 1'b1;
              run_cnt <= '0;
              err_run <= '0;
            end else begin
              run_cnt <= run_cnt + 16'd1;
            end
          end else begin
            run_cnt <= '0;
          end
        end
        S_LOCK: begin
          r <= {r[WIDTH-2:0], p};
          if (I != p) begin
            if (err_run + 8'd1 == ERR_TARGET) begin
              state    <= S_FILL;
              LOCKED   <= 1'b0;
              fill_cnt <= '0;
              err_run  <= '0;
            end else begin
              err_run <= err_run + 8'd1;
            end
          end else begin
            err_run <= '0;
          end
        end
        default: begin
          state  <= S_FILL;
          LOCKED <= 1'b0;
        end
      endcase
    end
  end

  // Error pulse and saturating statistics; CLR wins over a same-cycle increment
  always_ff @(posedge CLK) begin
    if (RST) begin
      ERROR     <= 1'b0;
      ERR_COUNT <= '0;
      BIT_COUNT <= '0;
    end else begin
      ERROR <= mismatch;
      if (check_en && (BIT_COUNT != CNT_MAX)) begin
        BIT_COUNT <= BIT_COUNT + CNT_ONE;
      end
      if (mismatch && (ERR_COUNT != CNT_MAX)) begin
        ERR_COUNT <= ERR_COUNT + CNT_ONE;
      end
      if (CLR) begin
        ERR_COUNT <= '0;
        BIT_COUNT <= '0;
      end
    end
  end

`ifdef LFSR_CHECKER_FIRST_ERR_EN
  logic                 captured;
  logic [CNT_WIDTH-1:0] first_err_q;

  // Capture the 0-based index of the first bad bit; only RST or CLR rearm it
  always_ff @(posedge CLK) begin
    if (RST) begin
      captured    <= 1'b0;
      first_err_q <= '0;
    end else if (CLR) begin
      captured    <= 1'b0;
      first_err_q <= '0;
    end else if (mismatch && !captured) begin
      captured    <= 1'b1;
      first_err_q <= BIT_COUNT;
    end
  end

  assign FIRST_ERR = first_err_q;
`else
  assign FIRST_ERR = '0;
`endif

endmodule

// File: tb/tb_lfsr_checker.sv
// tb/tb_lfsr_checker.sv - scoreboard bench for lfsr_checker against a bit-history reference model
module tb_lfsr_checker;

  localparam int          W           = 16;
  localparam logic [15:0] POLY_P      = 16'hD008;
  localparam int          LOCK_COUNT  = 64;
  localparam int          UNLOCK_ERRS = 8;
  localparam longint      SAT         = 64'hFFFF_FFFF;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        CE  = 1'b0;
  logic        I   = 1'b0;
  logic        CLR = 1'b0;
  logic        LOCKED;
  logic        ERROR;
  logic [31:0] ERR_COUNT;
  logic [31:0] BIT_COUNT;
  logic [31:0] FIRST_ERR;

  always #5 CLK = ~CLK;

  lfsr_checker #(
    .WIDTH(W), .POLY(POLY_P), .LOCK_COUNT(LOCK_COUNT),
    .UNLOCK_ERRS(UNLOCK_ERRS), .CNT_WIDTH(32)
  ) dut (
    .CLK(CLK), .RST(RST), .CE(CE), .I(I), .CLR(CLR),
    .LOCKED(LOCKED), .ERROR(ERROR), .ERR_COUNT(ERR_COUNT),
    .BIT_COUNT(BIT_COUNT), .FIRST_ERR(FIRST_ERR)
  );

  typedef struct packed {
    logic        locked;
    logic        error;
    logic [31:0] ec;
    logic [31:0] bc;
    logic [31:0] fe;
  } snap_t;

  snap_t exp_q[$];
  int    checks = 0;
  int    errors = 0;

  function automatic void chk(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  // Reference model: mode 0=fill 1=acquire 2=lock, history of the last W bits (newest last)
  logic [15:0] poly_v = POLY_P;
  int          m_mode, m_fill, m_run, m_erun;
  bit          m_hist[$];
  longint      m_ec, m_bc, m_fe;
  bit          m_cap, m_err;

  function automatic void m_reset();
    m_mode = 0; m_fill = 0; m_run = 0; m_erun = 0;
    m_hist.delete();
    for (int k = 0; k < W; k++) m_hist.push_back(1'b0);
    m_ec = 0; m_bc = 0; m_fe = 0; m_cap = 0; m_err = 0;
  endfunction

  function automatic bit m_pred();
    bit pv = 1'b0;
    for (int k = 0; k < W; k++) if (poly_v[k]) pv ^= m_hist[W-1-k];
    return pv;
  endfunction

  function automatic bit m_nonzero();
    for (int k = 0; k < W; k++) if (m_hist[k]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void m_push(bit b);
    m_hist.push_back(b);
    void'(m_hist.pop_front());
  endfunction

  function automatic void model(bit ce, bit ib, bit clr, bit rst);
    bit pv;
    if (rst) begin
      m_reset();
      return;
    end
    m_err = 1'b0;
    if (ce) begin
      pv = m_pred();
      if (m_mode == 0) begin
        m_push(ib);
        m_fill++;
        if (m_fill == W) begin m_mode = 1; m_run = 0; end
      end else if (m_mode == 1) begin
        if (ib == pv && m_nonzero()) m_run++; else m_run = 0;
        m_push(ib);
        if (m_run == LOCK_COUNT) begin m_mode = 2; m_erun = 0; end
      end else begin
        if (ib != pv) begin
          m_err = 1'b1;
          if (m_ec != SAT) m_ec++;
          if (!m_cap) begin m_fe = m_bc; m_cap = 1'b1; end
          m_erun++;
          if (m_erun == UNLOCK_ERRS) begin m_mode = 0; m_fill = 0; m_erun = 0; end
        end else begin
          m_erun = 0;
        end
        if (m_bc != SAT) m_bc++;
        m_push(pv);
      end
    end
    if (clr) begin m_ec = 0; m_bc = 0; m_fe = 0; m_cap = 0; end
  endfunction

  function automatic snap_t m_snap();
    snap_t s;
    s.locked = (m_mode == 2);
    s.error  = m_err;
    s.ec     = 32'(m_ec);
    s.bc     = 32'(m_bc);
`ifdef LFSR_CHECKER_FIRST_ERR_EN
    s.fe     = 32'(m_fe);
`else
    s.fe     = 32'd0;
`endif
    return s;
  endfunction

  // Pattern generator, advanced only on CE-high cycles
  logic [15:0] g = 16'h0001;

  function automatic bit gen_next();
    bit fb = ^(g & POLY_P);
    g = {g[14:0], fb};
    return fb;
  endfunction

  task automatic step(input bit ce, input bit ib, input bit clr, input bit rst);
    @(negedge CLK);
    CE = ce; I = ib; CLR = clr; RST = rst;
    @(posedge CLK);
    model(ce, ib, clr, rst);
    exp_q.push_back(m_snap());
    #1;
  endtask

  task automatic gstep(input bit ce, input bit flip, input bit clr);
    bit b;
    if (ce) b = gen_next() ^ flip;
    else    b = 1'($urandom);
    step(ce, b, clr, 1'b0);
  endtask

  task automatic do_reset();
    g = 16'h0001;
    step(1'b1, 1'($urandom), 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic wait_lock(input int max_n, output int n);
    n = 0;
    while (!LOCKED && n < max_n) begin
      gstep(1'b1, 1'b0, 1'b0);
      n++;
    end
  endtask

  // Monitor: every post-edge sample is matched against the oldest pending expectation
  initial begin : monitor
    snap_t e, a;
    forever begin
      @(posedge CLK);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {LOCKED, ERROR, ERR_COUNT, BIT_COUNT, FIRST_ERR};
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL scoreboard t=%0t: got locked=%0b error=%0b ec=%0d bc=%0d fe=%0d expected locked=%0b error=%0b ec=%0d bc=%0d fe=%0d",
                   $time, a.locked, a.error, a.ec, a.bc, a.fe, e.locked, e.error, e.ec, e.bc, e.fe);
        end
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin : driver
    int     n;
    int     ones;
    longint ec0;
    m_reset();

    do_reset();
    chk("reset_locked", LOCKED, 0);
    chk("reset_err_count", ERR_COUNT, 0);
    chk("reset_bit_count", BIT_COUNT, 0);

    wait_lock(200, n);
    chk("lock_latency", n, 80);

    while (m_bc < 100) gstep(1'b1, 1'b0, 1'b0);
    gstep(1'b1, 1'b1, 1'b0);
    chk("single_err_pulse", ERROR, 1);
    chk("single_err_count", ERR_COUNT, 1);
    chk("single_err_locked", LOCKED, 1);
    chk("single_err_bit_count", BIT_COUNT, 101);
`ifdef LFSR_CHECKER_FIRST_ERR_EN
    chk("first_err_index", FIRST_ERR, 100);
`endif
    gstep(1'b1, 1'b0, 1'b0);
    chk("error_one_cycle", ERROR, 0);

    repeat (300) gstep(1'b1, $urandom_range(0, 39) == 0, 1'b0);

    wait_lock(200, n);
    n = 0;
    while (LOCKED && n < 20) begin gstep(1'b1, 1'b1, 1'b0); n++; end
    chk("unlock_after_inverted_run", n, UNLOCK_ERRS);
    wait_lock(200, n);
    chk("relock_latency", n, 80);

    ec0 = m_ec; ones = 0; n = 0;
    while (LOCKED && n < 5000) begin
      if (gen_next()) ones++;
      step(1'b1, 1'b0, 1'b0, 1'b0);
      n++;
    end
    chk("zero_force_unlocked", LOCKED, 0);
    chk("zero_force_err_count", ERR_COUNT, ec0 + ones);
    wait_lock(200, n);
    chk("relock_after_zeros", n, 80);

    gstep(1'b1, 1'b0, 1'b1);
    chk("clr_err_count", ERR_COUNT, 0);
    repeat (3) begin
      gstep(1'b1, 1'b1, 1'b0);
      repeat (4) gstep(1'b1, 1'b0, 1'b0);
    end
    chk("three_errors", ERR_COUNT, 3);
    gstep(1'b1, 1'b1, 1'b1);
    chk("clr_with_err_ec", ERR_COUNT, 0);
    chk("clr_with_err_bc", BIT_COUNT, 0);
    chk("clr_with_err_fe", FIRST_ERR, 0);
    chk("clr_with_err_locked", LOCKED, 1);

    do_reset();
    repeat (500) step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("stuck_zero_locked", LOCKED, 0);
    chk("stuck_zero_err_count", ERR_COUNT, 0);

    do_reset();
    n = 0;
    while (!LOCKED && n < 400) begin
      n++;
      gstep(n % 2 == 0, 1'b0, 1'b0);
    end
    chk("lock_ce_toggle", n, 160);
    chk("ce_toggle_err_count", ERR_COUNT, 0);

    repeat (600) gstep($urandom_range(0, 3) != 0, $urandom_range(0, 29) == 0,
                       $urandom_range(0, 99) == 0);

    wait_lock(200, n);
    chk("locked_before_rst", LOCKED, 1);
    step(1'b1, 1'($urandom), 1'b1, 1'b1);
    chk("rst_mid_lock_locked", LOCKED, 0);
    chk("rst_mid_lock_ec", ERR_COUNT, 0);
    chk("rst_mid_lock_bc", BIT_COUNT, 0);
    chk("rst_mid_lock_error", ERROR, 0);

    repeat (3) @(posedge CLK);
    #3;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
